mem_writeback_stage: RTL and testbench

//  Stage directly downstream of the ALU in the single-issue CPU. Accepts one retired
//  ALU op per handshake, performs load/store against a private data RAM, and writes

---
 rtl/cpu_isa_pkg.sv | 38 +++
 rtl/mem_writeback_stage_if.sv | 19 +
 rtl/mem_writeback_stage_wb_data_ram.sv | 32 +++
 rtl/mem_writeback_stage.sv | 122 ++++++++++++
 tb/tb_mem_writeback_stage.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_isa_pkg.sv
// Opcode constants, writeback FSM states and op-class decode shared by the
// CPU pipeline stages.
package cpu_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd10;
  localparam logic [5:0] OP_BNE   = 6'd11;
  localparam logic [5:0] OP_LW    = 6'd12;
  localparam logic [5:0] OP_SW    = 6'd13;
  localparam logic [5:0] OP_ADDI  = 6'd15;
  localparam logic [5:0] OP_J     = 6'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_MEM_WAIT
  } wb_state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_OTHER
  } op_class_e;

  function automatic op_class_e op_class(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
      6'd6, 6'd7, 6'd8, 6'd9, OP_ADDI:  return CLS_ALU;
      OP_LW:                            return CLS_LOAD;
      OP_SW:                            return CLS_STORE;
      OP_BEQ, OP_BNE, OP_J:             return CLS_BRANCH;
      default:                          return CLS_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/mem_writeback_stage_if.sv
// Retiring-op handshake from the ALU into the memory/writeback stage.
interface mem_writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic [31:0] in_store_data;

  modport master (
    output in_valid, in_opcode, in_rd, in_result, in_store_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_result, in_store_data,
    output in_ready
  );
endinterface

// File: rtl/mem_writeback_stage_wb_data_ram.sv
// Private data RAM: one write port, one registered read port, async clear.
module wb_data_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data holds until the next read, so a load can consume it late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_writeback_stage.sv
// Memory/writeback stage: load/store against the private data RAM, register
// file writeback with read-port bypass, and the handshake FSM.
module mem_writeback_stage
  import cpu_isa_pkg::*;
#(
  parameter int DMEM_DEPTH = 32,
  parameter int MEM_LAT    = 2,
  parameter int DADDR_W    = $clog2(DMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_writeback_stage_if.slave   alu,
  input  logic [4:0]             rs_addr,
  input  logic [4:0]             rt_addr,
  output logic [31:0]            rs_data,
  output logic [31:0]            rt_data,
  output logic                   wb_valid,
  output logic [4:0]             wb_addr,
  output logic [31:0]            wb_data,
  output logic                   err_addr
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  wb_state_e          state_q, state_d;
  op_class_e          cls;
  logic               accept, oor;
  logic [CNT_W-1:0]   cnt_q;
  logic               ld_err_q, err_q;
  logic [4:0]         rd_q;
  logic [31:0]        result_q;
  logic [31:0]        ram_rdata;
  logic [31:0]        regs [32];

  assign cls    = op_class(alu.in_opcode);
  assign accept = alu.in_valid && (state_q == ST_IDLE);
  assign oor    = alu.in_result >= 32'(DMEM_DEPTH);

  wb_data_ram #(.DEPTH(DMEM_DEPTH), .ADDR_W(DADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && (cls == CLS_STORE) && !oor),
    .waddr (alu.in_result[DADDR_W-1:0]),
    .wdata (alu.in_store_data),
    .re    (accept && (cls == CLS_LOAD) && !oor),
    .raddr (alu.in_result[DADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ld_err_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && ((cls == CLS_LOAD) || (cls == CLS_STORE)) && oor;
      if (accept && (cls == CLS_LOAD)) begin
        cnt_q    <= CNT_W'(MEM_LAT - 1);
        ld_err_q <= oor;
      end else if ((state_q == ST_MEM_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Captured operands are only observed while wb_valid gates them.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q     <= alu.in_rd;
      result_q <= alu.in_result;
    end
  end

  always_comb begin
    state_d      = state_q;
    alu.in_ready = 1'b0;
    wb_valid     = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;
    case (state_q)
      ST_IDLE: begin
        alu.in_ready = 1'b1;
        if (alu.in_valid) begin
          if (cls == CLS_ALU)       state_d = ST_WRITE;
          else if (cls == CLS_LOAD) state_d = ST_MEM_WAIT;
        end
      end
      ST_WRITE: begin
        wb_valid = 1'b1;
        wb_addr  = rd_q;
        wb_data  = result_q;
        state_d  = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        if (cnt_q == '0) begin
          wb_valid = 1'b1;
          wb_addr  = rd_q;
          wb_data  = ld_err_q ? 32'd0 : ram_rdata;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_addr = err_q;

  // r0 is never written, so it keeps its reset image of 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i + 1);
    end else if (wb_valid && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign rs_data = (wb_valid && (wb_addr != 5'd0) && (wb_addr == rs_addr)) ? wb_data : regs[rs_addr];
  assign rt_data = (wb_valid && (wb_addr != 5'd0) && (wb_addr == rt_addr)) ? wb_data : regs[rt_addr];

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Scoreboard bench for mem_writeback_stage: random and directed ops checked
// against a register/RAM reference model.
module tb_mem_writeback_stage;

  localparam int DEPTH   = 32;
  localparam int MEM_LAT = 2;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_valid, err_addr;
  logic [4:0]  wb_addr;

  mem_writeback_stage_if bus ();

  mem_writeback_stage #(.DMEM_DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .DADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu      (bus.slave),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          busy_until = 0;
  wb_exp_t     wbq [$];
  int          errq [$];
  logic [31:0] mreg [32];
  logic [31:0] mram [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'(i + 1);
    for (int i = 0; i < DEPTH; i++) mram[i] = '0;
    wbq.delete();
    errq.delete();
    busy_until = 0;
  endtask

  // Reset asserted asynchronously just after a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rd,
                      input logic [31:0] res, input logic [31:0] sd);
    int n;
    int acc;
    bit oor;
    wb_exp_t e;
    n = 0;
    bus.in_valid      = 1'b1;
    bus.in_opcode     = op;
    bus.in_rd         = rd;
    bus.in_result     = res;
    bus.in_store_data = sd;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    oor = (res >= DEPTH);
    if (op <= 6'd9 || op == 6'd15) begin
      e.due = acc + 1; e.addr = rd; e.data = res;
      wbq.push_back(e);
      if (rd != 0) mreg[rd] = res;
      busy_until = acc + 2;
    end else if (op == 6'd12) begin
      e.due = acc + MEM_LAT; e.addr = rd; e.data = oor ? 32'd0 : mram[res % DEPTH];
      wbq.push_back(e);
      if (rd != 0) mreg[rd] = e.data;
      busy_until = acc + 1 + MEM_LAT;
      if (oor) errq.push_back(acc + 1);
    end else if (op == 6'd13) begin
      if (oor) errq.push_back(acc + 1);
      else     mram[res % DEPTH] = sd;
    end
  endtask

  task automatic drain();
    repeat (MEM_LAT + 3) @(posedge clk);
    #1;
    chk("sb_wb_empty", 32'(wbq.size()), 32'd0);
    chk("sb_err_empty", 32'(errq.size()), 32'd0);
  endtask

  task automatic chk_reg(input logic [4:0] a);
    rs_addr = a;
    rt_addr = 5'd31 - a;
    #1;
    chk($sformatf("rs_data[%0d]", a), rs_data, mreg[a]);
    chk($sformatf("rt_data[%0d]", 5'd31 - a), rt_data, mreg[5'd31 - a]);
  endtask

  // Monitor: pops expectations whenever the DUT presents a writeback or error.
  always @(negedge clk) begin
    wb_exp_t e;
    if (!rst) begin
      chk("in_ready", 32'(bus.in_ready), 32'(cyc >= busy_until));
      if (wb_valid) begin
        if (wbq.size() == 0) begin
          chk("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          e = wbq.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(e.due));
          chk("wb_addr", 32'(wb_addr), 32'(e.addr));
          chk("wb_data", wb_data, e.data);
        end
      end else if (wbq.size() != 0 && wbq[0].due <= cyc) begin
        chk("wb_missing", 32'(wb_valid), 32'd1);
        void'(wbq.pop_front());
      end
      if (err_addr) begin
        if (errq.size() == 0) chk("err_unexpected", 32'(err_addr), 32'd0);
        else chk("err_cycle", 32'(cyc), 32'(errq.pop_front()));
      end else if (errq.size() != 0 && errq[0] <= cyc) begin
        chk("err_missing", 32'(err_addr), 32'd1);
        void'(errq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] res;
    int          r;
    bus.in_valid = 1'b0;
    bus.in_opcode = '0;
    bus.in_rd = '0;
    bus.in_result = '0;
    bus.in_store_data = '0;
    model_reset();
    @(posedge clk);
    #1 do_reset();

    // Reset state
    rs_addr = 5'd3;
    #1;
    chk("reset_rs3", rs_data, 32'd4);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_wb_addr", 32'(wb_addr), 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_err", 32'(err_addr), 32'd0);

    // ALU write with same-cycle bypass
    send(6'd0, 5'd5, 32'h1234, 32'd0);
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    #1;
    chk("bypass_rs", rs_data, 32'h1234);
    chk("bypass_rt", rt_data, 32'h1234);
    drain();
    chk_reg(5'd5);

    // r0 write dropped, then back-to-back branch/jump
    send(6'd0, 5'd0, 32'h55, 32'd0);
    drain();
    chk_reg(5'd0);
    send(6'd10, 5'd7, 32'h9, 32'd0);
    send(6'd17, 5'd8, 32'hA, 32'd0);
    send(6'd11, 5'd9, 32'hB, 32'd0);
    drain();

    // Store then load, with a held op stalled behind the load
    send(6'd13, 5'd0, 32'd7, 32'hDEAD);
    send(6'd12, 5'd9, 32'd7, 32'd0);
    send(6'd15, 5'd3, 32'hCAFE, 32'd0);
    drain();
    chk_reg(5'd9);
    chk_reg(5'd3);

    // Out-of-range load and store
    send(6'd12, 5'd9, 32'd40, 32'd0);
    send(6'd13, 5'd0, 32'd40, 32'hBEEF);
    send(6'd12, 5'd10, 32'd8, 32'd0);
    drain();
    chk_reg(5'd9);
    chk_reg(5'd10);

    // Reset in the middle of a load
    send(6'd12, 5'd4, 32'd7, 32'd0);
    do_reset();
    drain();
    for (int i = 0; i < 32; i++) chk_reg(5'(i));

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      res = $urandom;
      if (r <= 3) begin
        op = (($urandom_range(0, 10)) == 10) ? 6'd15 : 6'($urandom_range(0, 9));
      end else if (r <= 5) begin
        op = 6'd12; res = $urandom_range(0, 39);
      end else if (r <= 7) begin
        op = 6'd13; res = $urandom_range(0, 39);
      end else if (r == 8) begin
        op = (($urandom_range(0, 2)) == 0) ? 6'd10 : ((($urandom_range(0, 1)) == 0) ? 6'd11 : 6'd17);
      end else begin
        op = 6'($urandom_range(18, 63));
      end
      send(op, 5'($urandom_range(0, 31)), res, $urandom);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    for (int i = 0; i < 32; i++) chk_reg(5'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
